// File: rtl/cpu_pkg.sv
// Shared constants and types for the LEGv8 pipeline.
// Instruction field positions, default address width / reset PC, and the
// next-PC selection type used by the fetch stage.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF   = 64;
  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned OPCODE_MSB   = 31;
  localparam int unsigned OPCODE_LSB   = 21;
  localparam int unsigned OPCODE_W     = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int unsigned IMM26_MSB    = 25;
  localparam int unsigned IMM26_LSB    = 0;
  localparam int unsigned IMM19_MSB    = 23;
  localparam int unsigned IMM19_LSB    = 5;
  localparam int unsigned WORD_BYTES   = 4;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;

  typedef enum logic [1:0] {
    NextHold,
    NextBranch,
    NextSeq
  } next_sel_e;

endpackage

// File: rtl/br_target_calc.sv
// Branch target calculator (purely combinational).
// Ports:
//   if_id_pc_i   PC of the branch instruction in ID
//   imm_field_i  instr[25:0] of the branch instruction
//   uncond_br_i  1: Imm26 offset, 0: Imm19 offset (instr[23:5])
//   pc_rd_i      1: register target (BR)
//   br_reg_i     register value for BR
//   target_o     computed branch target
module br_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned AddrW = ADDR_W_DEF
) (
  input  logic [AddrW-1:0] if_id_pc_i,
  input  logic [25:0]      imm_field_i,
  input  logic             uncond_br_i,
  input  logic             pc_rd_i,
  input  logic [AddrW-1:0] br_reg_i,
  output logic [AddrW-1:0] target_o
);

  logic signed [25:0] imm26;
  logic signed [18:0] imm19;
  logic [AddrW-1:0]   imm_sext;
  logic [AddrW-1:0]   pc_rel;
  logic               unused_br_reg_lsbs;

  assign imm26 = imm_field_i[IMM26_MSB:IMM26_LSB];
  assign imm19 = imm_field_i[IMM19_MSB:IMM19_LSB];

  // Sign-extend to the full width first, then scale to bytes.
  always_comb begin
    imm_sext = uncond_br_i ? AddrW'(imm26) : AddrW'(imm19);
  end

  assign pc_rel = if_id_pc_i + (imm_sext << 2);

  // BR targets are forced word-aligned.
  assign target_o = pc_rd_i ? {br_reg_i[AddrW-1:2], 2'b00} : pc_rel;

  assign unused_br_reg_lsbs = ^br_reg_i[1:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// Holds the PC, drives the combinational instruction-memory address and
// registers the fetched word with its PC. Taken branches redirect the PC with
// one delay slot: the instruction fetched in the redirect cycle always commits.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   imem_addr/rdata     instruction memory (combinational read)
//   stall               hold PC and IF/ID
//   br_taken/uncond_br/pc_rd/br_reg  branch resolution from ID
//   if_id_instr/pc/valid, opcode     IF/ID register contents
// Optional: define FETCH_PERF_CNT_EN to add fetch_cnt / redirect_cnt outputs.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                br_taken,
  input  logic                uncond_br,
  input  logic                pc_rd,
  input  logic [ADDR_W-1:0]   br_reg,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic [ADDR_W-1:0]   if_id_pc,
  output logic                if_id_valid,
  output logic [OPCODE_W-1:0] opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         redirect_cnt
`endif
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  br_target;
  next_sel_e          next_sel;

  br_target_calc #(
    .AddrW (ADDR_W)
  ) u_br_target_calc (
    .if_id_pc_i  (ipc_q),
    .imm_field_i (instr_q[25:0]),
    .uncond_br_i (uncond_br),
    .pc_rd_i     (pc_rd),
    .br_reg_i    (br_reg),
    .target_o    (br_target)
  );

  // Stall wins; a branch only counts when ID holds a real instruction.
  always_comb begin
    next_sel = NextSeq;
    if (stall) begin
      next_sel = NextHold;
    end else if (br_taken && valid_q) begin
      next_sel = NextBranch;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    unique case (next_sel)
      NextHold: ;
      NextBranch: begin
        pc_d    = br_target;
        instr_d = imem_rdata;
        ipc_d   = pc_q;
        valid_d = 1'b1;
      end
      default: begin
        pc_d    = pc_q + ADDR_W'(WORD_BYTES);
        instr_d = imem_rdata;
        ipc_d   = pc_q;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_valid = valid_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (next_sel != NextHold) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (next_sel == NextBranch) begin
      redirect_cnt_d = redirect_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// branch/stall traffic, compared against a behavioural pipeline model.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, br_taken, uncond_br, pc_rd;
  logic [63:0] br_reg;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;
  logic [10:0] opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, redirect_cnt;
`endif

  fetch_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .br_taken     (br_taken),
    .uncond_br    (uncond_br),
    .pc_rd        (pc_rd),
    .br_reg       (br_reg),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid),
    .opcode       (opcode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Sparse instruction memory; unwritten words come from a distinct-per-address pattern.
  logic [31:0] mem [logic [63:0]];

  function automatic logic [31:0] mem_read(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] * 16'd40503, a[15:0]} ^ 32'h5a00_00a5;
  endfunction

  // Reference model state.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr;
  logic        m_valid;
  int unsigned m_fetch, m_redir;

  function automatic void model_reset();
    m_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_fetch = 0; m_redir = 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".addr"}, imem_addr, m_pc);
    check({tag, ".instr"}, {32'h0, if_id_instr}, {32'h0, m_instr});
    check({tag, ".ipc"}, if_id_pc, m_ipc);
    check({tag, ".valid"}, {63'h0, if_id_valid}, {63'h0, m_valid});
    check({tag, ".opcode"}, {53'h0, opcode}, {53'h0, m_instr[31:21]});
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".fcnt"}, {32'h0, fetch_cnt}, {32'h0, m_fetch});
    check({tag, ".rcnt"}, {32'h0, redirect_cnt}, {32'h0, m_redir});
`endif
  endtask

  // One clock: apply inputs, advance the model, compare just after the edge.
  task automatic step(input bit st, input bit bt, input bit ub, input bit prd,
                      input logic [63:0] breg);
    logic [63:0]        tgt;
    logic signed [25:0] i26;
    logic signed [18:0] i19;
    longint             off;
    bit                 taken;
    stall = st; br_taken = bt; uncond_br = ub; pc_rd = prd; br_reg = breg;
    imem_rdata = mem_read(imem_addr);
    @(posedge clk);
    if (!st) begin
      taken = bt && m_valid;
      i26 = m_instr[25:0];
      i19 = m_instr[23:5];
      off = ub ? longint'(i26) : longint'(i19);
      tgt = prd ? (breg & ~64'h3) : m_ipc + 64'(off * 4);
      m_instr = mem_read(m_pc);
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_pc    = taken ? tgt : m_pc + 64'd4;
      m_fetch++;
      if (taken) m_redir++;
    end
    #1;
    compare_all("step");
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 64'h0);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any edge.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("areset");
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; stall = 0; br_taken = 0; uncond_br = 0; pc_rd = 0;
    br_reg = 64'h0; imem_rdata = 32'h0;
    model_reset();
    mem[64'h8]  = {6'b000101, 26'd3};                   // B +3 words
    mem[64'h40] = {8'b1011_0100, 19'h7fffe, 5'd0};      // CBZ -2 words
    #12;
    compare_all("reset");
    reset_n = 1'b1;

    // Sequential fetch.
    step(0, 0, 0, 0, 64'h0);
    check("seq0.ipc", if_id_pc, 64'h0);
    check("seq0.valid", {63'h0, if_id_valid}, 64'h1);
    run_seq(2);
    check("seq2.ipc", if_id_pc, 64'h8);

    // B at PC 8: delay slot at 12, then target 20.
    step(0, 1, 1, 0, 64'h0);
    check("b.ds", if_id_pc, 64'hc);
    check("b.pc", imem_addr, 64'h14);
    step(0, 0, 0, 0, 64'h0);
    check("b.tgt", if_id_pc, 64'h14);

    // CBZ at 0x40 with negative offset; then BR with unaligned register.
    async_reset();
    run_seq(17);
    check("cbz.at", if_id_pc, 64'h40);
    step(0, 1, 0, 0, 64'h0);
    check("cbz.ds", if_id_pc, 64'h44);
    step(0, 0, 0, 0, 64'h0);
    check("cbz.tgt", if_id_pc, 64'h38);
    step(0, 1, 0, 1, 64'h103);
    step(0, 0, 0, 0, 64'h0);
    check("br.tgt", if_id_pc, 64'h100);

    // Stall with branch pending for 3 cycles, then redirect once.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 64'h200);
    check("stall.ipc", if_id_pc, 64'h100);
    step(0, 1, 0, 1, 64'h200);
    check("stall.pc", imem_addr, 64'h200);
    step(0, 0, 0, 0, 64'h0);
    check("stall.tgt", if_id_pc, 64'h200);

    // Reset mid-branch, then restart at the reset PC.
    stall = 0; br_taken = 1; pc_rd = 1; br_reg = 64'h300;
    async_reset();
    step(0, 1, 0, 1, 64'h300);                          // ignored: IF/ID not valid
    check("rst.restart", if_id_pc, 64'h0);
    check("rst.pc", imem_addr, 64'h4);

`ifdef FETCH_PERF_CNT_EN
    // 10 fetches, 2 taken branches, 1 stall.
    async_reset();
    for (int i = 0; i < 11; i++) step(i == 8, (i == 3) || (i == 6), 1, 0, 64'h0);
    check("cnt.fetch", {32'h0, fetch_cnt}, 64'd10);
    check("cnt.redir", {32'h0, redirect_cnt}, 64'd2);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      step($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           $urandom_range(0, 3) == 0, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
